// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - tick-driven LED pattern sequencer (rotate left/right, ping-pong, flash)
module led_sequencer #(
  parameter int NB_LEDS = 4,
  parameter int NB_MODE = 2
) (
  input  logic               clock,
  input  logic               i_reset_n,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic [NB_MODE-1:0] i_mode,
  output logic [NB_LEDS-1:0] o_led,
  output logic               o_step,
  output logic               o_wrap
);

  typedef enum logic [1:0] {
    MODE_LEFT  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_PING  = 2'b10,
    MODE_FLASH = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [NB_LEDS-1:0] SEED_LSB  = NB_LEDS'(1);
  localparam logic [NB_LEDS-1:0] SEED_MSB  = {1'b1, {(NB_LEDS-1){1'b0}}};
  localparam logic [NB_LEDS-1:0] SEED_ONES = '1;

  logic [NB_LEDS-1:0] r_led;
  mode_t              r_mode_q;
  dir_t               r_dir;
  logic               r_valid_d;
  logic               r_step;
  logic               r_wrap;

  logic [NB_LEDS-1:0] w_led_nxt;
  mode_t              w_mode_nxt;
  dir_t               w_dir_nxt;
  logic               w_step_nxt;
  logic               w_wrap_nxt;
  logic               w_tick;
  mode_t              w_mode_in;
  logic [NB_LEDS-1:0] w_shl;
  logic [NB_LEDS-1:0] w_shr;

  // Only a rising edge of i_valid counts; edges seen while disabled are dropped.
  assign w_tick    = i_valid & ~r_valid_d & i_enable;
  assign w_mode_in = mode_t'(i_mode);
  assign w_shl     = r_led << 1;
  assign w_shr     = r_led >> 1;

  always_comb begin
    w_led_nxt  = r_led;
    w_mode_nxt = r_mode_q;
    w_dir_nxt  = r_dir;
    w_step_nxt = 1'b0;
    w_wrap_nxt = 1'b0;
    if (w_tick) begin
      w_step_nxt = 1'b1;
      if (w_mode_in != r_mode_q) begin
        w_mode_nxt = w_mode_in;
        w_dir_nxt  = DIR_UP;
        case (w_mode_in)
          MODE_LEFT:  w_led_nxt = SEED_LSB;
          MODE_RIGHT: w_led_nxt = SEED_MSB;
          MODE_PING:  w_led_nxt = SEED_LSB;
          MODE_FLASH: w_led_nxt = SEED_ONES;
          default:    w_led_nxt = SEED_LSB;
        endcase
      end else begin
        case (r_mode_q)
          MODE_LEFT: begin
            w_led_nxt  = {r_led[NB_LEDS-2:0], r_led[NB_LEDS-1]};
            w_wrap_nxt = r_led[NB_LEDS-1];
          end
          MODE_RIGHT: begin
            w_led_nxt  = {r_led[0], r_led[NB_LEDS-1:1]};
            w_wrap_nxt = r_led[0];
          end
          MODE_PING: begin
            // Direction flips on the step that lands on an end LED.
            if (r_dir == DIR_UP) begin
              w_led_nxt = w_shl;
              if (w_shl[NB_LEDS-1]) w_dir_nxt = DIR_DOWN;
            end else begin
              w_led_nxt = w_shr;
              if (w_shr[0]) begin
                w_dir_nxt  = DIR_UP;
                w_wrap_nxt = 1'b1;
              end
            end
          end
          MODE_FLASH: begin
            w_led_nxt  = ~r_led;
            w_wrap_nxt = (r_led == '0);
          end
          default: w_led_nxt = r_led;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_led     <= SEED_LSB;
      r_mode_q  <= MODE_LEFT;
      r_dir     <= DIR_UP;
      r_valid_d <= 1'b0;
      r_step    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_led     <= w_led_nxt;
      r_mode_q  <= w_mode_nxt;
      r_dir     <= w_dir_nxt;
      r_valid_d <= i_valid;
      r_step    <= w_step_nxt;
      r_wrap    <= w_wrap_nxt;
    end
  end

  assign o_led  = r_led;
  assign o_step = r_step;
  assign o_wrap = r_wrap;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - directed-vector bench for led_sequencer
module tb_led_sequencer;

  logic       clock;
  logic       i_reset_n;
  logic       i_valid;
  logic       i_enable;
  logic [1:0] i_mode;
  logic [3:0] o_led;
  logic       o_step;
  logic       o_wrap;

  int n_vec;
  int n_miss;
  int n_steps;

  led_sequencer #(.NB_LEDS(4), .NB_MODE(2)) dut (
    .clock     (clock),
    .i_reset_n (i_reset_n),
    .i_valid   (i_valid),
    .i_enable  (i_enable),
    .i_mode    (i_mode),
    .o_led     (o_led),
    .o_step    (o_step),
    .o_wrap    (o_wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle valid pulse, result checked one cycle later, then idle to 4-cycle spacing.
  task automatic tick_check(input string tag, input logic [3:0] exp_led, input logic exp_wrap);
    @(negedge clock);
    i_valid = 1'b1;
    @(negedge clock);
    i_valid = 1'b0;
    check({tag, ".led"}, 32'(o_led), 32'(exp_led));
    check({tag, ".step"}, 32'(o_step), 32'd1);
    check({tag, ".wrap"}, 32'(o_wrap), 32'(exp_wrap));
    @(negedge clock);
    check({tag, ".step_w"}, 32'(o_step), 32'd0);
    check({tag, ".wrap_w"}, 32'(o_wrap), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_enable  = 1'b1;
    i_mode    = 2'b00;
    repeat (3) @(negedge clock);
    check("rst.led", 32'(o_led), 32'h1);
    check("rst.step", 32'(o_step), 32'd0);
    check("rst.wrap", 32'(o_wrap), 32'd0);
    i_reset_n = 1'b1;
    @(negedge clock);

    // rotate left
    tick_check("rl1", 4'b0010, 1'b0);
    tick_check("rl2", 4'b0100, 1'b0);
    tick_check("rl3", 4'b1000, 1'b0);
    tick_check("rl4", 4'b0001, 1'b1);
    tick_check("rl5", 4'b0010, 1'b0);

    // asynchronous reset while o_step is high
    @(negedge clock);
    i_valid = 1'b1;
    @(posedge clock);
    #2;
    check("arst.pre_led", 32'(o_led), 32'b0100);
    check("arst.pre_step", 32'(o_step), 32'd1);
    i_reset_n = 1'b0;
    #1;
    check("arst.led", 32'(o_led), 32'h1);
    check("arst.step", 32'(o_step), 32'd0);
    @(negedge clock);
    i_valid = 1'b0;
    @(negedge clock);
    i_reset_n = 1'b1;
    @(negedge clock);

    // ping-pong
    i_mode = 2'b10;
    tick_check("pp_seed", 4'b0001, 1'b0);
    tick_check("pp1", 4'b0010, 1'b0);
    tick_check("pp2", 4'b0100, 1'b0);
    tick_check("pp3", 4'b1000, 1'b0);
    tick_check("pp4", 4'b0100, 1'b0);
    tick_check("pp5", 4'b0010, 1'b0);
    tick_check("pp6", 4'b0001, 1'b1);
    tick_check("pp7", 4'b0010, 1'b0);

    // held valid: one step only
    n_steps = 0;
    @(negedge clock);
    i_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (o_step) n_steps++;
    end
    check("held.steps", 32'(n_steps), 32'd1);
    check("held.led", 32'(o_led), 32'b0100);
    i_valid = 1'b0;
    @(negedge clock);
    i_valid = 1'b1;
    @(negedge clock);
    check("held.re_step", 32'(o_step), 32'd1);
    check("held.re_led", 32'(o_led), 32'b1000);
    i_valid = 1'b0;
    @(negedge clock);

    // enable gating: frozen at 1000 with dir down
    i_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      i_valid = 1'b1;
      @(negedge clock);
      i_valid = 1'b0;
      check("gate.led", 32'(o_led), 32'b1000);
      check("gate.step", 32'(o_step), 32'd0);
      check("gate.wrap", 32'(o_wrap), 32'd0);
    end
    @(negedge clock);
    i_enable = 1'b1;
    tick_check("gate.resume", 4'b0100, 1'b0);

    // rotate right
    i_mode = 2'b01;
    tick_check("rr_seed", 4'b1000, 1'b0);
    tick_check("rr1", 4'b0100, 1'b0);
    tick_check("rr2", 4'b0010, 1'b0);
    tick_check("rr3", 4'b0001, 1'b0);
    tick_check("rr4", 4'b1000, 1'b1);

    // back to left, reach 0100, then flash
    i_mode = 2'b00;
    tick_check("l_seed", 4'b0001, 1'b0);
    tick_check("l1", 4'b0010, 1'b0);
    tick_check("l2", 4'b0100, 1'b0);
    i_mode = 2'b11;
    repeat (2) @(negedge clock);
    check("idle_mode.led", 32'(o_led), 32'b0100);
    tick_check("fl_seed", 4'b1111, 1'b0);
    tick_check("fl1", 4'b0000, 1'b0);
    tick_check("fl2", 4'b1111, 1'b1);

    // back-to-back 1-0-1 ticks
    @(negedge clock);
    i_valid = 1'b1;
    @(negedge clock);
    i_valid = 1'b0;
    check("b2b.step1", 32'(o_step), 32'd1);
    check("b2b.led1", 32'(o_led), 32'b0000);
    @(negedge clock);
    i_valid = 1'b1;
    check("b2b.gap", 32'(o_step), 32'd0);
    @(negedge clock);
    i_valid = 1'b0;
    check("b2b.step2", 32'(o_step), 32'd1);
    check("b2b.led2", 32'(o_led), 32'b1111);
    check("b2b.wrap2", 32'(o_wrap), 32'd1);
    repeat (2) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Consumes the periodic `valid` strobe from the lab's programmable tick counter and advances a visible LED pattern by one step per strobe. It is the downstream end of the counter's tick interface. It converts each tick into a shift, bounce or flash step selected by switches, and drives the board LEDs directly. It also reports one-cycle step and wrap pulses for chaining or debug.

## Interface
- `NB_LEDS`, default 4: number of LEDs driven; must be ≥ 2.
- `NB_MODE`, default 2: width of the mode select; fixed at 2, no other value is supported.
- `clock`, input, 1: the single clock; all logic is posedge.
- `i_reset_n`, input, 1: asynchronous, active-low reset.
- `i_valid`, input, 1: tick from the counter; may be held high indefinitely when the counter is paused.
- `i_enable`, input, 1: when 0, ticks are ignored and the pattern freezes.
- `i_mode`, input, NB_MODE: 00 rotate left, 01 rotate right, 10 ping-pong, 11 flash.
- `o_led`, output, NB_LEDS: the LED pattern, registered.
- `o_step`, output, 1: one-cycle pulse, high in the cycle `o_led` takes a new value.
- `o_wrap`, output, 1: one-cycle pulse, high when the pattern returns to its mode seed.

## Operation
- **Tick detect.**
  - `valid_d` is `i_valid` registered.
  - `tick = i_valid & ~valid_d & i_enable`, so only rising edges count.
  - A rising edge while `i_enable` = 0 is discarded, not queued.
  - A held-high `i_valid` produces exactly one tick.
- **Mode latch.** `mode_q` holds the mode of the current pattern and is updated only on a tick.
- **On tick with `i_mode != mode_q`:**
  - load the seed of `i_mode` into `o_led`;
  - set `mode_q = i_mode` and `dir = up`;
  - `o_step` = 1, `o_wrap` = 0.
- **Seeds:**
  - left: LSB only (0001);
  - right: MSB only (1000);
  - ping-pong: 0001 with `dir` up;
  - flash: all ones (1111).
- **On tick with `i_mode == mode_q`, advance one step:**
  - **Rotate left:** `o_led` rotl 1. 1000→0001 asserts `o_wrap`.
  - **Rotate right:** `o_led` rotr 1. 0001→1000 asserts `o_wrap`.
  - **Ping-pong:**
    - `dir` up shifts left; `dir` down shifts right.
    - When the shift lands on the MSB, `dir` becomes down.
    - When it lands on the LSB, `dir` becomes up.
    - The step that lands on 0001 (from 0010) asserts `o_wrap`.
    - Period is 2·(NB_LEDS−1) steps: 6 for the default.
  - **Flash:** `o_led` = ~`o_led`. 0000→1111 asserts `o_wrap`.
- **State.** Internal state is `o_led`, `mode_q`, `dir`, `valid_d`, and the `o_step`/`o_wrap` registers. The pattern is always one-hot in left, right and ping-pong modes.
- **No tick.** All state holds and `o_step` = `o_wrap` = 0.

## Timing
- **Reset** (asynchronous assert, all registers):
  - `o_led` = 0…01;
  - `mode_q` = 00, `dir` = up, `valid_d` = 0;
  - `o_step` = 0, `o_wrap` = 0.
- **Reset release.** If `i_valid` is already high at the first edge after release, one tick occurs (`valid_d` = 0). This is intended.
- **Latency.** `i_valid` is first seen high at edge N with `valid_d` = 0 and `i_enable` = 1. Then `o_led`, `o_step` and `o_wrap` update at edge N: visible one cycle after the rising edge was presented.
- **Pulse width.** `o_step` and `o_wrap` are high for exactly one cycle per tick.
- **Back-to-back ticks.** A 1-0-1 pattern on `i_valid` gives a tick every 2 cycles; that is the minimum spacing.
- **Mode changes.**
  - Changing `i_mode` between ticks has no effect until the next tick.
  - A mode change and a tick in the same cycle load the new seed; there is no advance.
- **Enable changes.**
  - Dropping `i_enable` mid-pattern freezes `o_led`.
  - Re-enabling resumes from the frozen value with `dir` preserved.
- **Reset mid-pattern.** Returns to the reset values immediately, without waiting for a clock edge.

## Test plan
- **Rotate left and reset:** reset, mode 00, enable 1, 5 single-cycle `i_valid` pulses spaced 4 cycles → `o_led` sequence 0010, 0100, 1000, 0001, 0010. `o_wrap` is high only on the 4th step. `o_step` pulses 5×, 1 cycle each. Finally, assert `i_reset_n` low with no clock edge → `o_led` = 0001 and `o_step` = 0 immediately.
- **Ping-pong:** mode 10 from reset → first tick loads seed 0001 with `o_wrap` = 0. The next 7 ticks give 0010, 0100, 1000, 0100, 0010, 0001, 0010. `o_wrap` is high on the 0001 step only.
- **Held valid:** `i_valid` held high 20 cycles → exactly one `o_step`. Drop it for 1 cycle and raise it again → a second step.
- **Enable gating:** `i_enable` = 0 with 3 valid edges → `o_led` unchanged and no pulses. Re-enable and give 1 edge → a single advance from the frozen value.
- **Mode switch and flash:** from left pattern 0100, set mode 11 and tick → 1111, no wrap. Tick → 0000. Tick → 1111 with `o_wrap` = 1.
